boot_mem_unit: RTL and testbench

- Unified 256 x 15-bit instruction/data memory on the processor's external bus (`MemWrite`, `Adr`, 15-bit `MemData`).
- After reset it holds the processor in reset and accepts a serial program image, MSB first. It then releases the processor and serves its reads and writes.
- Uses the same two-phase clocking as the processor core.
- One cycle = one ph2 high phase followed by one ph1 high phase. State is captured in a master latch on ph2 and a slave latch on ph1.

---
 rtl/boot_mem_unit.sv | 151 +++++++++++++++
 tb/tb_boot_mem_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/boot_mem_unit.sv
// boot_mem_unit: 256x15 unified memory with serial boot image loader.
// Optional: define BOOT_MEM_WRITE_PROTECT_EN to make loaded words read-only.
module boot_mem_unit #(
   parameter int DEPTH  = 256,
   parameter int WORD_W = 15
) (
   input  logic             ph1,
   input  logic             ph2,
   input  logic             reset,
   input  logic             load_valid,
   input  logic             load_bit,
   output logic             cpu_reset,
   output logic             load_done,
   output logic             protect_err,
   input  logic             mem_write,
   input  logic [7:0]       adr,
   inout  wire [WORD_W-1:0] mem_data
);

   typedef enum logic [1:0] {
      S_COUNT = 2'd0,
      S_WORD  = 2'd1,
      S_RUN   = 2'd2
   } st_t;

   typedef struct packed {
      st_t              st;
      logic [3:0]       bit_cnt;
      logic [7:0]       wr_ptr;
      logic [WORD_W-1:0] shift;
      logic [8:0]       words_left;
`ifdef BOOT_MEM_WRITE_PROTECT_EN
      logic [8:0]       wcount;
      logic             perr;
`endif
   } ctx_t;

   logic [WORD_W-1:0] mem [DEPTH];

   ctx_t              q, n, m;
   logic              we_n, we_m;
   logic [7:0]        wa_n, wa_m;
   logic [WORD_W-1:0] wd_n, wd_m;
   logic [7:0]        cnt;
   logic              blk;

   // next-state, load sequencing and memory write request
   always_comb begin
      n    = q;
      we_n = 1'b0;
      wa_n = q.wr_ptr;
      wd_n = '0;
      cnt  = {q.shift[6:0], load_bit};
`ifdef BOOT_MEM_WRITE_PROTECT_EN
      blk  = ({1'b0, adr} < q.wcount);
`else
      blk  = 1'b0;
`endif
      if (reset) begin
         n.st         = S_COUNT;
         n.bit_cnt    = '0;
         n.wr_ptr     = '0;
         n.shift      = '0;
         n.words_left = '0;
`ifdef BOOT_MEM_WRITE_PROTECT_EN
         n.wcount     = '0;
         n.perr       = 1'b0;
`endif
      end else begin
         unique case (q.st)
            S_COUNT: begin
               if (load_valid) begin
                  n.shift = {q.shift[13:0], load_bit};
                  if (q.bit_cnt == 4'd7) begin
                     n.bit_cnt    = '0;
                     n.words_left = {(cnt == 8'd0), cnt};
`ifdef BOOT_MEM_WRITE_PROTECT_EN
                     n.wcount     = {(cnt == 8'd0), cnt};
`endif
                     n.st         = S_WORD;
                  end else begin
                     n.bit_cnt = q.bit_cnt + 4'd1;
                  end
               end
            end
            S_WORD: begin
               if (load_valid) begin
                  n.shift = {q.shift[13:0], load_bit};
                  if (q.bit_cnt == 4'd14) begin
                     we_n         = 1'b1;
                     wa_n         = q.wr_ptr;
                     wd_n         = {q.shift[13:0], load_bit};
                     n.wr_ptr     = q.wr_ptr + 8'd1;
                     n.words_left = q.words_left - 9'd1;
                     n.bit_cnt    = '0;
                     if (q.words_left == 9'd1)
                        n.st = S_RUN;
                  end else begin
                     n.bit_cnt = q.bit_cnt + 4'd1;
                  end
               end
            end
            S_RUN: begin
               if (mem_write) begin
                  if (blk) begin
`ifdef BOOT_MEM_WRITE_PROTECT_EN
                     n.perr = 1'b1;
`endif
                  end else begin
                     we_n = 1'b1;
                     wa_n = adr;
                     wd_n = (mem[adr] & 15'h7F00)
                          | (mem_data & 15'h00FF);
                  end
               end
            end
            default: n.st = S_COUNT;
         endcase
      end
   end

   // master stage: captured as ph2 closes
   always_ff @(negedge ph2) begin
      m    <= n;
      we_m <= we_n;
      wa_m <= wa_n;
      wd_m <= wd_n;
   end

   // slave stage: state becomes visible at ph1
   always_ff @(posedge ph1) begin
      q <= m;
   end

   // memory array commits pending write at ph1
   always_ff @(posedge ph1) begin
      if (we_m)
         mem[wa_m] <= wd_m;
   end

   assign load_done = (q.st == S_RUN);
   assign cpu_reset = ~load_done;
`ifdef BOOT_MEM_WRITE_PROTECT_EN
   assign protect_err = q.perr;
`else
   assign protect_err = 1'b0;
`endif

   assign mem_data = (load_done & ~mem_write) ? mem[adr] : 'z;

endmodule

// File: tb/tb_boot_mem_unit.sv
// tb_boot_mem_unit: directed boot-load and bus tests for boot_mem_unit.
// Reads are checked by a monitor against a queue of expected words.
module tb_boot_mem_unit;

   logic        ph1, ph2, reset;
   logic        load_valid, load_bit;
   logic        cpu_reset, load_done, protect_err;
   logic        mem_write;
   logic [7:0]  adr;
   wire  [14:0] mem_data;
   logic        drv;
   logic [14:0] bus_v;
   logic        rd_en;

   int total;
   int bad;

   logic [14:0] exp_q [$];
   string       nm_q  [$];
   logic [14:0] img   [256];

   assign mem_data = drv ? bus_v : 'z;

   boot_mem_unit dut (
      .ph1        (ph1),
      .ph2        (ph2),
      .reset      (reset),
      .load_valid (load_valid),
      .load_bit   (load_bit),
      .cpu_reset  (cpu_reset),
      .load_done  (load_done),
      .protect_err(protect_err),
      .mem_write  (mem_write),
      .adr        (adr),
      .mem_data   (mem_data)
   );

   // two-phase non-overlapping clock, period 10
   initial begin
      ph1 = 0;
      ph2 = 0;
      forever begin
         #1 ph2 = 1;
         #3 ph2 = 0;
         #1 ph1 = 1;
         #4 ph1 = 0;
         #1;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: timeout reached, required finish");
      $fatal(1);
   end

   // monitor: compare bus during ph2 of each read cycle
   always @(posedge ph2) begin
      logic [14:0] e;
      string       s;
      #1;
      if (rd_en) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL rd_unexpected: got %h, required none", mem_data);
         end else begin
            e = exp_q.pop_front();
            s = nm_q.pop_front();
            if (mem_data !== e) begin
               bad++;
               $display("FAIL %s: got %h, required %h", s, mem_data, e);
            end
         end
      end
   end

   task automatic check(input string s, input logic [31:0] act,
                        input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", s, act, req);
      end
   endtask

   task automatic cyc();
      @(negedge ph1);
   endtask

   task automatic rst();
      reset = 1;
      cyc();
      cyc();
      reset = 0;
   endtask

   task automatic send(input logic [14:0] v, input int nb, input bit gap);
      for (int i = nb - 1; i >= 0; i--) begin
         load_valid = 1;
         load_bit   = v[i];
         cyc();
         load_valid = 0;
         if (gap) cyc();
      end
   endtask

   task automatic load(input logic [7:0] c, input bit gap, input string s);
      int nw;
      nw = (c == 8'd0) ? 256 : int'(c);
      send({7'd0, c}, 8, gap);
      for (int w = 0; w < nw - 1; w++)
         send(img[w], 15, gap);
      send(img[nw-1] >> 1, 14, gap);
      check({s, "_pre"}, {31'd0, cpu_reset}, 32'd1);
      send({14'd0, img[nw-1][0]}, 1, 1'b0);
      check({s, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd0);
      check({s, "_done"}, {31'd0, load_done}, 32'd1);
   endtask

   task automatic rd(input logic [7:0] a, input logic [14:0] e,
                     input string s);
      adr       = a;
      mem_write = 0;
      exp_q.push_back(e);
      nm_q.push_back(s);
      rd_en = 1;
      cyc();
      rd_en = 0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [14:0] d);
      adr       = a;
      mem_write = 1;
      drv       = 1;
      bus_v     = d;
      cyc();
      mem_write = 0;
      drv       = 0;
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      reset      = 0;
      load_valid = 0;
      load_bit   = 0;
      mem_write  = 0;
      adr        = 0;
      drv        = 0;
      bus_v      = 0;
      rd_en      = 0;
      cyc();
      rst();
      check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      check("rst_load_done", {31'd0, load_done}, 32'd0);
      check("rst_protect_err", {31'd0, protect_err}, 32'd0);

      // full 256-word image, word value = address
      for (int i = 0; i < 256; i++) img[i] = 15'(i);
      load(8'd0, 1'b0, "ld256");
      rd(8'd0, 15'd0, "rd256_0");
      rd(8'd128, 15'd128, "rd256_128");
      rd(8'd255, 15'd255, "rd256_255");

      // two words, continuous strobe
      rst();
      img[0] = 15'h1234;
      img[1] = 15'h7FFF;
      load(8'd2, 1'b0, "ld2");
      rd(8'd0, 15'h1234, "ld2_rd0");
      rd(8'd1, 15'h7FFF, "ld2_rd1");
      rd(8'd2, 15'd2, "ld2_rd2");
      send(15'h00FF, 8, 1'b0);
      check("run_ignores_load", {31'd0, load_done}, 32'd1);
      rd(8'd0, 15'h1234, "run_ign_rd0");

      // same image with gaps between bits
      rst();
      load(8'd2, 1'b1, "ld2gap");
      rd(8'd0, 15'h1234, "gap_rd0");
      rd(8'd1, 15'h7FFF, "gap_rd1");

      // aborted load then a one-word image
      rst();
      send(15'd3, 8, 1'b0);
      send(15'h0ABC, 12, 1'b0);
      rst();
      check("abort_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      img[0] = 15'h0042;
      load(8'd1, 1'b0, "ld1");
      rd(8'd0, 15'h0042, "ld1_rd0");
      rd(8'd1, 15'h7FFF, "ld1_rd1");

      // 17 words, last one 7F00 at 0x10
      rst();
      for (int i = 0; i < 16; i++) img[i] = 15'h0100 + 15'(i);
      img[16] = 15'h7F00;
      load(8'd17, 1'b0, "ld17");
      check("perr_before", {31'd0, protect_err}, 32'd0);
`ifdef BOOT_MEM_WRITE_PROTECT_EN
      wr(8'd2, 15'h00EE);
      check("perr_set", {31'd0, protect_err}, 32'd1);
      rd(8'd2, 15'h0102, "prot_rd2");
      wr(8'd16, 15'h55A5);
      rd(8'd16, 15'h7F00, "prot_rd16");
      wr(8'd17, 15'h55A5);
      rd(8'd17, 15'h00A5, "prot_rd17");
      cyc();
      check("perr_sticky", {31'd0, protect_err}, 32'd1);
      rst();
      check("perr_rst", {31'd0, protect_err}, 32'd0);
`else
      wr(8'h10, 15'h55A5);
      rd(8'h10, 15'h7FA5, "wr_rd10");
      rd(8'h0F, 15'h010F, "wr_rd0f");
      wr(8'd200, 15'h003C);
      rd(8'd200, 15'd200 & 15'h7F00 | 15'h003C, "wr_rd200");
      check("perr_off", {31'd0, protect_err}, 32'd0);
`endif
      cyc();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL rd_pending: got %0d, required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
